// File: rtl/keyboard_matrix_sched_if.sv
// Bus bundle between the keyboard matrix scheduler and its environment
// (PS/2 translator, injection source, frame timing and CPU I/O decode).
interface keyboard_matrix_sched_if;
  logic        ps2_valid;
  logic [3:0]  ps2_row;
  logic [2:0]  ps2_col;
  logic        ps2_release;
  logic        inj_valid;
  logic        inj_ready;
  logic [3:0]  inj_row;
  logic [2:0]  inj_col;
  logic        inj_shift;
  logic        tick;
  logic        clear;
  logic [13:0] cpu_ka;
  logic [6:0]  cpu_kd;
  logic        inj_busy;

  modport master (
    output ps2_valid, ps2_row, ps2_col, ps2_release,
    output inj_valid, inj_row, inj_col, inj_shift,
    output tick, clear, cpu_ka,
    input  inj_ready, cpu_kd, inj_busy
  );

  modport slave (
    input  ps2_valid, ps2_row, ps2_col, ps2_release,
    input  inj_valid, inj_row, inj_col, inj_shift,
    input  tick, clear, cpu_ka,
    output inj_ready, cpu_kd, inj_busy
  );
endinterface

// File: rtl/keyboard_matrix_sched.sv
// Keyboard matrix owner: merges live PS/2 key events with a queued
// key-injection stream replayed as timed press/hold/gap sequences, and
// serves active-low CPU row scans.
//
// state | meaning
// IDLE  | waiting for a queued injection entry
// PRESS | one cycle: drive the latched key (and SHIFT) into inj matrix
// HOLD  | key held, counting ticks until release
// GAP   | all injected keys released, counting ticks before next entry
module keyboard_matrix_sched #(
  parameter int HOLD_TICKS = 3,
  parameter int GAP_TICKS  = 2,
  parameter int FIFO_DEPTH = 8
) (
  input logic                    clk,
  input logic                    reset,
  keyboard_matrix_sched_if.slave bus
);

  localparam int HOLD_EFF = (HOLD_TICKS < 1) ? 1 : HOLD_TICKS;
  localparam int GAP_EFF  = (GAP_TICKS < 1) ? 1 : GAP_TICKS;
  localparam int MAX_T    = (HOLD_EFF > GAP_EFF) ? HOLD_EFF : GAP_EFF;
  localparam int CW       = $clog2(MAX_T + 1);
  localparam int AW       = $clog2(FIFO_DEPTH);
  localparam logic [CW-1:0] HOLD_LAST = CW'(HOLD_EFF - 1);
  localparam logic [CW-1:0] GAP_LAST  = CW'(GAP_EFF - 1);
  localparam logic [AW:0]   DEPTH_CNT = (AW + 1)'(FIFO_DEPTH);

  typedef enum logic [1:0] {S_IDLE, S_PRESS, S_HOLD, S_GAP} state_t;

  state_t             state_q, state_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [7:0]         ent_q, ent_d;
  logic [13:0][6:0]   live_q, live_d;
  logic [13:0][6:0]   inj_q, inj_d;
  logic [13:0][6:0]   eff_m;
  logic [6:0]         kd_q, kd_d;
  logic [AW:0]        wr_q, rd_q;
  logic [7:0]         mem_q [FIFO_DEPTH];
  logic [7:0]         head;
  logic               full, empty, push, pop;

  // Entry layout {shift, row[3:0], col[2:0]}; only in-matrix keys get pressed.
  function automatic logic key_ok(input logic [7:0] e);
    return (e[6:3] <= 4'd13) && (e[2:0] <= 3'd6);
  endfunction

  assign empty         = (wr_q == rd_q);
  assign full          = ((wr_q - rd_q) == DEPTH_CNT);
  assign bus.inj_ready = !reset && !full;
  assign push          = bus.inj_valid && bus.inj_ready && !bus.clear;
  assign head          = mem_q[rd_q[AW-1:0]];
  assign eff_m         = live_q | inj_q;
  assign bus.cpu_kd    = kd_q;
  assign bus.inj_busy  = !empty || (state_q != S_IDLE);

  // Live key events land directly in live_m; clear wins over a same-cycle event.
  always_comb begin
    live_d = live_q;
    if (bus.clear) begin
      live_d = '0;
    end else if (bus.ps2_valid && (bus.ps2_row <= 4'd13) && (bus.ps2_col <= 3'd6)) begin
      live_d[bus.ps2_row][bus.ps2_col] = ~bus.ps2_release;
    end
  end

  // CPU scan: OR every selected row of the effective matrix, invert for active-low data.
  always_comb begin
    logic [6:0] acc;
    acc = '0;
    for (int r = 0; r < 14; r++) begin
      if (!bus.cpu_ka[r]) acc = acc | eff_m[r];
    end
    kd_d = ~acc;
  end

  // Scheduler next-state: pop, press, hold and gap timing on tick pulses.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    ent_d   = ent_q;
    inj_d   = inj_q;
    pop     = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (!empty) begin
          pop   = 1'b1;
          ent_d = head;
          cnt_d = '0;
          // Out-of-matrix entries press nothing but still consume a gap slot.
          state_d = key_ok(head) ? S_PRESS : S_GAP;
        end
      end
      S_PRESS: begin
        inj_d[ent_q[6:3]][ent_q[2:0]] = 1'b1;
        if (ent_q[7]) inj_d[0][6] = 1'b1;
        cnt_d   = '0;
        state_d = S_HOLD;
      end
      S_HOLD: begin
        if (bus.tick) begin
          if (cnt_q == HOLD_LAST) begin
            inj_d   = '0;
            cnt_d   = '0;
            state_d = S_GAP;
          end else if (cnt_q != {CW{1'b1}}) begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      S_GAP: begin
        if (bus.tick) begin
          if (cnt_q == GAP_LAST) begin
            cnt_d   = '0;
            state_d = S_IDLE;
          end else if (cnt_q != {CW{1'b1}}) begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
    if (bus.clear) begin
      state_d = S_IDLE;
      cnt_d   = '0;
      inj_d   = '0;
      pop     = 1'b0;
    end
  end

  // State, matrices, scan output and FIFO pointers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      ent_q   <= '0;
      live_q  <= '0;
      inj_q   <= '0;
      kd_q    <= 7'h7F;
      wr_q    <= '0;
      rd_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ent_q   <= ent_d;
      live_q  <= live_d;
      inj_q   <= inj_d;
      kd_q    <= kd_d;
      if (bus.clear) begin
        wr_q <= '0;
        rd_q <= '0;
      end else begin
        wr_q <= wr_q + {{AW{1'b0}}, push};
        rd_q <= rd_q + {{AW{1'b0}}, pop};
      end
    end
  end

  // Injection queue storage; only written on an accepted push.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_q[AW-1:0]] <= {bus.inj_shift, bus.inj_row, bus.inj_col};
  end

endmodule

// File: tb/tb_keyboard_matrix_sched.sv
// Directed bench for keyboard_matrix_sched: expectations are queued when
// stimulus is applied and popped when the corresponding output is sampled.
module tb_keyboard_matrix_sched;
  logic clk = 1'b0;
  logic reset;
  int   passed = 0;
  int   total  = 0;
  int   fails  = 0;
  int   acc;

  typedef struct {
    string      tag;
    logic [7:0] val;
  } exp_t;
  exp_t sb[$];

  keyboard_matrix_sched_if bus();

  keyboard_matrix_sched #(
    .HOLD_TICKS(3),
    .GAP_TICKS (2),
    .FIFO_DEPTH(8)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic expect_v(input string tag, input logic [7:0] v);
    exp_t e;
    e.tag = tag;
    e.val = v;
    sb.push_back(e);
  endtask

  task automatic chk(input logic [7:0] obs);
    exp_t e;
    total++;
    if (sb.size() == 0) begin
      fails++;
      $error("FAIL sb_empty observed=%h expected=none", obs);
    end else begin
      e = sb.pop_front();
      assert (obs === e.val) passed++;
      else begin
        fails++;
        $error("FAIL %s observed=%h expected=%h", e.tag, obs, e.val);
      end
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic live_ev(input logic [3:0] r, input logic [2:0] c, input logic rel);
    bus.ps2_valid = 1'b1; bus.ps2_row = r; bus.ps2_col = c; bus.ps2_release = rel;
    @(negedge clk);
    bus.ps2_valid = 1'b0;
    @(negedge clk);
  endtask

  task automatic push(input logic s, input logic [3:0] r, input logic [2:0] c);
    bus.inj_valid = 1'b1; bus.inj_shift = s; bus.inj_row = r; bus.inj_col = c;
    @(negedge clk);
    bus.inj_valid = 1'b0;
  endtask

  task automatic pulse_tick(input int n);
    repeat (n) begin
      bus.tick = 1'b1;
      @(negedge clk);
      bus.tick = 1'b0;
    end
  endtask

  initial begin
    reset = 1'b1;
    bus.ps2_valid = 0; bus.ps2_row = 0; bus.ps2_col = 0; bus.ps2_release = 0;
    bus.inj_valid = 0; bus.inj_row = 0; bus.inj_col = 0; bus.inj_shift = 0;
    bus.tick = 0; bus.clear = 0; bus.cpu_ka = 14'h3FFF;
    cyc(3);
    expect_v("ready_in_reset", 8'h00); chk({7'd0, bus.inj_ready});
    expect_v("busy_in_reset", 8'h00);  chk({7'd0, bus.inj_busy});
    reset = 1'b0;
    bus.cpu_ka = 14'h3FFE;
    cyc(1);
    expect_v("kd_after_reset", 8'h7F);    chk({1'b0, bus.cpu_kd});
    expect_v("ready_after_reset", 8'h01); chk({7'd0, bus.inj_ready});
    expect_v("busy_after_reset", 8'h00);  chk({7'd0, bus.inj_busy});

    // Live press / release at row 3 col 5
    bus.cpu_ka = 14'h3FF7;
    live_ev(4'd3, 3'd5, 1'b0);
    expect_v("live_press_r3c5", 8'h5F); chk({1'b0, bus.cpu_kd});
    live_ev(4'd3, 3'd5, 1'b1);
    expect_v("live_release_r3c5", 8'h7F); chk({1'b0, bus.cpu_kd});

    // Multi-row read
    live_ev(4'd0, 3'd0, 1'b0);
    live_ev(4'd1, 3'd1, 1'b0);
    bus.cpu_ka = 14'h3FFC; cyc(1);
    expect_v("multirow_r0r1", 8'h7C); chk({1'b0, bus.cpu_kd});
    bus.cpu_ka = 14'h3FFE; cyc(1);
    expect_v("row0_only", 8'h7E); chk({1'b0, bus.cpu_kd});
    live_ev(4'd0, 3'd0, 1'b1);
    live_ev(4'd1, 3'd1, 1'b1);
    // Out-of-range live events are ignored
    live_ev(4'd14, 3'd0, 1'b0);
    live_ev(4'd2, 3'd7, 1'b0);
    bus.cpu_ka = 14'h0000; cyc(1);
    expect_v("live_out_of_range", 8'h7F); chk({1'b0, bus.cpu_kd});

    // Injection: shift + row 2 col 3, then a queued row 5 col 1
    bus.cpu_ka = 14'h3FFE;
    push(1'b1, 4'd2, 3'd3);
    expect_v("busy_after_push", 8'h01); chk({7'd0, bus.inj_busy});
    cyc(3);
    expect_v("inj_shift_row0", 8'h3F); chk({1'b0, bus.cpu_kd});
    bus.cpu_ka = 14'h3FFB; cyc(1);
    expect_v("inj_row2", 8'h77); chk({1'b0, bus.cpu_kd});
    push(1'b0, 4'd5, 3'd1);
    pulse_tick(2);
    expect_v("inj_row2_after_2_ticks", 8'h77); chk({1'b0, bus.cpu_kd});
    bus.cpu_ka = 14'h3FFE; cyc(1);
    expect_v("inj_row0_after_2_ticks", 8'h3F); chk({1'b0, bus.cpu_kd});
    bus.cpu_ka = 14'h3FFB;
    pulse_tick(1);
    cyc(1);
    expect_v("inj_released_3rd_tick", 8'h7F); chk({1'b0, bus.cpu_kd});
    bus.cpu_ka = 14'h0000; cyc(1);
    expect_v("gap_all_rows", 8'h7F); chk({1'b0, bus.cpu_kd});
    pulse_tick(1);
    cyc(2);
    expect_v("gap_after_1_tick", 8'h7F); chk({1'b0, bus.cpu_kd});
    pulse_tick(1);
    cyc(1);                        // FSM now in PRESS for the second entry
    bus.tick = 1'b1; cyc(1); bus.tick = 1'b0;
    expect_v("second_not_yet_visible", 8'h7F); chk({1'b0, bus.cpu_kd});
    cyc(1);
    expect_v("second_pressed", 8'h7D); chk({1'b0, bus.cpu_kd});
    pulse_tick(2);
    expect_v("press_tick_not_counted", 8'h7D); chk({1'b0, bus.cpu_kd});
    pulse_tick(1);
    cyc(1);
    expect_v("second_released", 8'h7F); chk({1'b0, bus.cpu_kd});
    pulse_tick(2);
    expect_v("busy_after_gap", 8'h00); chk({7'd0, bus.inj_busy});

    // Overlay: live activity on an injected key during HOLD
    bus.cpu_ka = 14'h3FEF;
    push(1'b0, 4'd4, 3'd0);
    cyc(3);
    expect_v("overlay_inj", 8'h7E); chk({1'b0, bus.cpu_kd});
    live_ev(4'd4, 3'd0, 1'b0);
    live_ev(4'd4, 3'd0, 1'b1);
    expect_v("overlay_live_release", 8'h7E); chk({1'b0, bus.cpu_kd});
    pulse_tick(3);
    cyc(1);
    expect_v("overlay_hold_end", 8'h7F); chk({1'b0, bus.cpu_kd});
    pulse_tick(2);

    // Out-of-range injected entry: accepted, presses nothing, still gaps
    bus.cpu_ka = 14'h0000;
    push(1'b0, 4'd15, 3'd0);
    cyc(3);
    expect_v("bad_entry_no_key", 8'h7F); chk({1'b0, bus.cpu_kd});
    expect_v("bad_entry_busy", 8'h01);   chk({7'd0, bus.inj_busy});
    pulse_tick(2);
    expect_v("bad_entry_gap_done", 8'h00); chk({7'd0, bus.inj_busy});

    // Fill the FIFO while the scheduler holds the first key
    acc = 0;
    bus.inj_valid = 1'b1; bus.inj_col = 3'd0; bus.inj_shift = 1'b0;
    for (int i = 0; i < 12; i++) begin
      bus.inj_row = 4'(acc);
      if (bus.inj_ready) acc++;
      cyc(1);
    end
    bus.inj_valid = 1'b0;
    expect_v("accepted_count", 8'd9);  chk(8'(acc));
    expect_v("ready_when_full", 8'h00); chk({7'd0, bus.inj_ready});
    expect_v("busy_when_full", 8'h01);  chk({7'd0, bus.inj_busy});
    expect_v("first_fill_key", 8'h7E);  chk({1'b0, bus.cpu_kd});
    live_ev(4'd7, 3'd2, 1'b0);
    expect_v("live_before_clear", 8'h7A); chk({1'b0, bus.cpu_kd});

    // clear mid-HOLD, with a same-cycle live event that must be dropped
    bus.clear = 1'b1;
    bus.ps2_valid = 1'b1; bus.ps2_row = 4'd7; bus.ps2_col = 3'd3; bus.ps2_release = 1'b0;
    cyc(1);
    bus.clear = 1'b0; bus.ps2_valid = 1'b0;
    expect_v("ready_after_clear", 8'h01); chk({7'd0, bus.inj_ready});
    expect_v("busy_after_clear", 8'h00);  chk({7'd0, bus.inj_busy});
    cyc(1);
    expect_v("kd_after_clear", 8'h7F); chk({1'b0, bus.cpu_kd});
    pulse_tick(5);
    cyc(3);
    expect_v("kd_flushed", 8'h7F);   chk({1'b0, bus.cpu_kd});
    expect_v("busy_flushed", 8'h00); chk({7'd0, bus.inj_busy});

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/keyboard_matrix_sched.md
Name: keyboard_matrix_sched

Overview:
- Owns the 14x7 keyboard matrix state and arbitrates writes to it from two sources:
  - live PS/2-translated key events, applied immediately;
  - a queued key-injection stream (autotype/paste from the MiST host), replayed as timed press/hold/release sequences.
- Serves CPU keyboard reads: the CPU selects rows with active-low address lines and receives active-low column data.
- Sits between the PS/2 scancode translator and the CPU I/O decode.

Parameters:
- HOLD_TICKS, 3, number of tick pulses an injected key is held pressed; 0 is treated as 1.
- GAP_TICKS, 2, number of tick pulses all injected keys stay released before the next injected key; 0 is treated as 1.
- FIFO_DEPTH, 8, injection queue depth in entries; power of two, at least 2.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- ps2_valid  in  1  one-cycle strobe: a live key event is present.
- ps2_row  in  4  matrix row of the live event (0..13).
- ps2_col  in  3  matrix column of the live event (0..6).
- ps2_release  in  1  1 = release, 0 = press.
- inj_valid  in  1  an injection entry is offered.
- inj_ready  out  1  FIFO can accept an entry.
- inj_row  in  4  row of the injected key.
- inj_col  in  3  column of the injected key.
- inj_shift  in  1  hold SHIFT (row 0, col 6) together with the injected key.
- tick  in  1  one-cycle frame-rate timing strobe.
- clear  in  1  one-cycle strobe: release all keys and flush injection.
- cpu_ka  in  14  row select, active low; several rows may be low at once.
- cpu_kd  out  7  column data, active low (0 = key pressed).
- inj_busy  out  1  FIFO non-empty or scheduler not IDLE.

Behaviour:
- Storage: two 14x7 bit arrays, live_m and inj_m (1 = pressed). Effective matrix eff_m = live_m OR inj_m, so a live release never clears an injected key and vice versa.
- Reset (synchronous): live_m = 0, inj_m = 0, FIFO empty, FSM in IDLE, tick counter = 0, cpu_kd = 7'h7F, inj_ready = 0 during reset, inj_busy = 0.
- Live path:
  - On ps2_valid with ps2_row <= 13 and ps2_col <= 6: live_m[row][col] <= ~ps2_release.
  - Out-of-range row or col: event ignored.
  - Update is visible in eff_m on the next cycle.
- CPU read:
  - cpu_kd is registered with 1-cycle latency.
  - Each cycle, cpu_kd <= ~(OR of eff_m[r] over every r where cpu_ka[r] == 0).
  - cpu_ka all ones gives 7'h7F.
- FIFO:
  - inj_ready = !full.
  - Push when inj_valid && inj_ready; entry = {shift, row, col}.
  - Entries with out-of-range row or col are accepted and then discarded at pop (no key pressed; FSM goes straight to GAP).
  - Simultaneous push and pop on a full FIFO is not allowed, because ready is already low.
  - Simultaneous push and pop on a non-full FIFO keeps the count unchanged.
- Scheduler FSM (states IDLE, PRESS, HOLD, GAP):
  - IDLE: if FIFO non-empty, pop and latch the entry; go to PRESS.
  - PRESS (1 cycle): set inj_m[row][col]; if shift, also set inj_m[0][6]. Clear the tick counter; go to HOLD.
  - HOLD: count tick pulses. At the max(HOLD_TICKS,1)-th tick, clear inj_m entirely, clear the counter, go to GAP.
  - GAP: count ticks. At the max(GAP_TICKS,1)-th tick, go to IDLE.
  - The earliest next pop is the cycle after GAP exits.
- clear strobe:
  - Next cycle: live_m = 0, inj_m = 0, FIFO flushed, FSM in IDLE, counter = 0.
  - clear has priority over a same-cycle ps2_valid and over a same-cycle push; both are dropped.
- tick arriving in the same cycle as the PRESS state is not counted.
- Counters saturate and never wrap; counter width is clog2(max(HOLD_TICKS,GAP_TICKS)+1).

Test Plan:
- Reset, then cpu_ka = 14'h3FFE -> cpu_kd = 7'h7F; inj_ready = 1 and inj_busy = 0 one cycle after reset deasserts.
- Live press at row 3, col 5, then cpu_ka = ~14'h0008 -> cpu_kd = 7'h5F two cycles after the strobe. Then live release at row 3, col 5 -> cpu_kd = 7'h7F.
- Multi-row read: press at row 0 col 0 and row 1 col 1; cpu_ka = 14'h3FFC -> cpu_kd = 7'h7C. cpu_ka = 14'h3FFE -> cpu_kd = 7'h7E.
- Injection with HOLD=3, GAP=2: push {shift=1, row 2, col 3} -> row 0 reads 7'h3F and row 2 reads 7'h77 from PRESS until the 3rd tick. All rows then read 7'h7F. A second queued entry is pressed only after 2 further ticks.
- Overlay: inject row 4 col 0 while a live press and then live release of row 4 col 0 occur during HOLD -> the key still reads pressed until HOLD ends.
- Fill 8 entries -> inj_ready = 0 and a 9th offer is ignored. clear mid-HOLD -> next cycle all rows read 7'h7F, inj_busy = 0, inj_ready = 1.
